// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter.
//   - FSM state encodings (kept as plain 2-bit constants)
//   - port identifier used to remember which requester was last served
//   - helper for the byte-strobe width derived from the data width
package mem_port_arbiter_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY_IF = 2'd1;
  localparam logic [1:0] ST_BUSY_DM = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_DM = 1'b1
  } port_t;

  function automatic int strb_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported unified memory between the instruction fetch
// port (if_*) and the data access port (dm_*). Data has priority; a
// starvation counter forces a fetch grant after STARVE_LIMIT consecutive data
// grants taken while a fetch was waiting.
//
// Ports
//   clk, rst                      clock (rising edge), synchronous active-high reset
//   if_req/if_addr                fetch request, held until if_ready
//   if_rdata/if_ready/if_stall    fetched word, one-cycle completion pulse, stall
//   dm_req/dm_we/dm_wstrb/
//   dm_addr/dm_wdata              data request, held until dm_ready
//   dm_rdata/dm_ready/dm_stall    read data, one-cycle completion pulse, stall
//   mem_req/mem_we/mem_wstrb/
//   mem_addr/mem_wdata            memory command, held until mem_ack
//   mem_rdata/mem_ack             memory response
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_IDLE    | no access in flight, arbitrate
// ST_BUSY_IF | fetch command on the memory bus, waiting for mem_ack
// ST_BUSY_DM | data command on the memory bus, waiting for mem_ack
// ST_DONE    | ready pulse to the served port, arbitrate the next one
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ready,
  output logic                if_stall,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [DATA_W/8-1:0] dm_wstrb,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_ready,
  output logic                dm_stall,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack
);

  localparam int STRB_W = strb_width(DATA_W);
  localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [1:0]       state;
  port_t            served;
  logic [CNT_W-1:0] starve_cnt;

  logic arb_en;
  logic if_cand;
  logic dm_cand;
  logic starved;
  logic grant_if;
  logic grant_dm;

  // In DONE the served port still holds its req during the ready cycle;
  // that stale request must not win a second grant.
  always_comb begin
    arb_en   = (state == ST_IDLE) || (state == ST_DONE);
    if_cand  = if_req & ~((state == ST_DONE) && (served == PORT_IF));
    dm_cand  = dm_req & ~((state == ST_DONE) && (served == PORT_DM));
    starved  = (starve_cnt == CNT_MAX);
    grant_if = arb_en & if_cand & (~dm_cand | starved);
    grant_dm = arb_en & dm_cand & ~grant_if;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      served    <= PORT_IF;
      mem_we    <= 1'b0;
      mem_wstrb <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      case (state)
        ST_BUSY_IF: begin
          if (mem_ack) begin
            if_rdata <= mem_rdata;
            state    <= ST_DONE;
          end
        end
        ST_BUSY_DM: begin
          if (mem_ack) begin
            if (!mem_we) begin
              dm_rdata <= mem_rdata;
            end
            state <= ST_DONE;
          end
        end
        default: begin
          if (grant_if) begin
            state     <= ST_BUSY_IF;
            served    <= PORT_IF;
            mem_we    <= 1'b0;
            mem_wstrb <= '0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
          end else if (grant_dm) begin
            state     <= ST_BUSY_DM;
            served    <= PORT_DM;
            mem_we    <= dm_we;
            mem_wstrb <= dm_we ? dm_wstrb : {STRB_W{1'b0}};
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Counts data grants that bypassed a waiting fetch; any fetch grant or an
  // idle fetch port resets the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!if_req || grant_if) begin
      starve_cnt <= '0;
    end else if (grant_dm && !starved) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_comb begin
    mem_req  = (state == ST_BUSY_IF) || (state == ST_BUSY_DM);
    if_ready = (state == ST_DONE) && (served == PORT_IF);
    dm_ready = (state == ST_DONE) && (served == PORT_DM);
    if_stall = if_req & ~if_ready;
    dm_stall = dm_req & ~dm_ready;
  end

endmodule
